// File: rtl/crc5_query_ctrl.sv
// Query frame receive controller: steers decoded bits into an external CRC-5
// checker, captures the command code and Query parameters, and reports the result.
module crc5_query_ctrl #(
    parameter int                 CMD_LEN    = 4,
    parameter int                 QUERY_LEN  = 22,
    parameter logic [CMD_LEN-1:0] QUERY_CODE = 4'b1000
) (
    input  logic               clk_crc5,
    input  logic               rst_for_new_package,
    input  logic               frame_start,
    input  logic               frame_abort,
    input  logic               data,
    input  logic               data_valid,
    input  logic               crc5_check_pass,
    output logic               crc5_rst_n,
    output logic               crc5_data,
    output logic               crc5_sync,
    output logic               crc5_package_complete,
    output logic               busy,
    output logic               query_ok,
    output logic               query_crc_err,
    output logic               not_query,
    output logic [CMD_LEN-1:0] cmd_code,
    output logic [12:0]        query_param,
    output logic [2:0]         state_dbg
);

    localparam int CW = $clog2(QUERY_LEN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        BODY   = 3'd2,
        WAIT   = 3'd3,
        SAMPLE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CMD_LEN-1:0] cmd_q, cmd_d;
    logic [12:0]        shadow_q, shadow_d;
    logic [12:0]        param_q, param_d;
    logic               sync_q, sync_d;
    logic               cdata_q, cdata_d;
    logic               rst_n_q, rst_n_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic               nq_q, nq_d;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        shadow_d = shadow_q;
        param_d  = param_q;
        sync_d   = 1'b0;
        cdata_d  = cdata_q;
        rst_n_d  = 1'b1;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        nq_d     = 1'b0;
        accept   = data_valid && (state_q == HEADER || state_q == BODY);

        // A new delimiter wins over everything else in the same cycle.
        if (frame_start) begin
            state_d = HEADER;
            cnt_d   = '0;
            rst_n_d = 1'b0;
        end else if (frame_abort) begin
            state_d = IDLE;
        end else begin
            if (accept) begin
                sync_d  = 1'b1;
                cdata_d = data;
                if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
            end
            case (state_q)
                HEADER: begin
                    if (data_valid) begin
                        cmd_d = {cmd_q[CMD_LEN-2:0], data};
                        if (cnt_q == CW'(CMD_LEN - 1)) begin
                            if (cmd_d == QUERY_CODE) begin
                                state_d = BODY;
                            end else begin
                                state_d = IDLE;
                                nq_d    = 1'b1;
                            end
                        end
                    end
                end
                BODY: begin
                    if (data_valid) begin
                        if (cnt_q <= CW'(QUERY_LEN - 6)) shadow_d = {shadow_q[11:0], data};
                        if (cnt_q == CW'(QUERY_LEN - 1)) state_d = WAIT;
                    end
                end
                // One cycle for the checker to absorb the final bit.
                WAIT: state_d = SAMPLE;
                SAMPLE: begin
                    state_d = IDLE;
                    if (crc5_check_pass) begin
                        ok_d    = 1'b1;
                        param_d = shadow_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_crc5) begin
        if (rst_for_new_package) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            shadow_q <= '0;
            param_q  <= '0;
            sync_q   <= 1'b0;
            cdata_q  <= 1'b0;
            rst_n_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            nq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            shadow_q <= shadow_d;
            param_q  <= param_d;
            sync_q   <= sync_d;
            cdata_q  <= cdata_d;
            rst_n_q  <= rst_n_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            nq_q     <= nq_d;
        end
    end

    assign crc5_rst_n            = rst_n_q;
    assign crc5_data             = cdata_q;
    assign crc5_sync             = sync_q;
    assign crc5_package_complete = (state_q == IDLE) || (state_q == WAIT) || (state_q == SAMPLE);
    assign busy                  = (state_q != IDLE);
    assign query_ok              = ok_q;
    assign query_crc_err         = err_q;
    assign not_query             = nq_q;
    assign cmd_code              = cmd_q;
    assign query_param           = param_q;
    assign state_dbg             = state_q;

endmodule

// File: tb/tb_crc5_query_ctrl.sv
// Bench for crc5_query_ctrl: behavioural CRC-5 checker, directed frames,
// expected-result queue drained by an independent result monitor.
module tb_crc5_query_ctrl;

    localparam int W = 35;  // {kind[1:0], cmd[3:0], param[12:0], cycle[15:0]}
    localparam logic [21:0] GOOD = 22'b1000_0_00_0_00_00_0_0000_10000;
    localparam logic [21:0] BAD  = 22'b1000_0_00_0_00_00_0_0000_10001;
    localparam logic [12:0] P    = 13'b1011001010011;

    logic        clk_crc5 = 1'b0;
    logic        rst_for_new_package = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_abort = 1'b0;
    logic        data = 1'b0;
    logic        data_valid = 1'b0;
    logic        crc5_check_pass;
    logic        crc5_rst_n, crc5_data, crc5_sync, crc5_package_complete;
    logic        busy, query_ok, query_crc_err, not_query;
    logic [3:0]  cmd_code;
    logic [12:0] query_param;
    logic [2:0]  state_dbg;

    int          cyc = 0;
    int          last_cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;
    logic [4:0]  crc_q = 5'b01001;
    logic [21:0] pframe;

    always #5 clk_crc5 = ~clk_crc5;
    always @(posedge clk_crc5) cyc <= cyc + 1;

    crc5_query_ctrl dut (
        .clk_crc5(clk_crc5), .rst_for_new_package(rst_for_new_package),
        .frame_start(frame_start), .frame_abort(frame_abort),
        .data(data), .data_valid(data_valid), .crc5_check_pass(crc5_check_pass),
        .crc5_rst_n(crc5_rst_n), .crc5_data(crc5_data), .crc5_sync(crc5_sync),
        .crc5_package_complete(crc5_package_complete), .busy(busy),
        .query_ok(query_ok), .query_crc_err(query_crc_err), .not_query(not_query),
        .cmd_code(cmd_code), .query_param(query_param), .state_dbg(state_dbg)
    );

    // Gen2 CRC-5 (x^5 + x^3 + 1, preset 01001); a good frame leaves zero residue.
    function automatic logic [4:0] crc_step(input logic [4:0] c, input logic d);
        logic [4:0] s;
        s = {c[3:0], 1'b0};
        return (c[4] ^ d) ? (s ^ 5'b01001) : s;
    endfunction

    function automatic logic [4:0] crc5_of(input logic [16:0] b);
        logic [4:0] c;
        c = 5'b01001;
        for (int i = 16; i >= 0; i--) c = crc_step(c, b[i]);
        return c;
    endfunction

    always @(posedge clk_crc5) begin
        if (!crc5_rst_n) crc_q <= 5'b01001;
        else if (crc5_sync) crc_q <= crc_step(crc_q, crc5_data);
    end
    assign crc5_check_pass = (crc_q == 5'd0);

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_crc5);
        #1;
    endtask

    task automatic push(input logic [1:0] kind, input logic [3:0] cmd, input logic [12:0] prm,
                        input int at);
        logic [15:0] at16;
        at16 = 16'(at);
        exp_q.push_back({kind, cmd, prm, at16});
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        data = b;
        data_valid = 1'b1;
        last_cyc = cyc;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [21:0] fr, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            send_bit(fr[21-i]);
        end
    endtask

    // Result monitor: every pulse must match the head of the expected queue.
    always @(negedge clk_crc5) begin
        if (query_ok || query_crc_err || not_query) begin
            mon_act = {query_crc_err | not_query, query_ok | not_query, cmd_code, query_param,
                       cyc[15:0]};
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got %h expected none", mon_act);
            end else begin
                check("result", mon_act, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pframe = {4'b1000, P, crc5_of({4'b1000, P})};
        #1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_pulses", {query_ok, query_crc_err, not_query}, 0);
        check("rst_sync_data", {crc5_sync, crc5_data}, 0);
        check("rst_pkg_complete", crc5_package_complete, 1);
        check("rst_crc_rst_n", crc5_rst_n, 0);
        check("rst_cmd_param", {cmd_code, query_param}, 0);
        rst_for_new_package = 1'b0;
        repeat (2) tick();

        // Good Query, all-zero parameters.
        start();
        check("start_rst_n_low", crc5_rst_n, 0);
        check("start_busy_pkg", {busy, crc5_package_complete}, 2'b10);
        send_frame(GOOD, 22, 0);
        push(2'b01, 4'b1000, 13'd0, last_cyc + 3);
        check("wait_busy_pkg", {busy, crc5_package_complete}, 2'b11);
        check("last_bit_forwarded", {crc5_sync, crc5_data}, 2'b10);
        repeat (5) tick();
        check("ok_done_busy", busy, 0);

        // Good Query with non-trivial parameters, bits spaced apart.
        start();
        send_frame(pframe, 22, 1);
        push(2'b01, 4'b1000, P, last_cyc + 3);
        repeat (5) tick();

        // Corrupted CRC: error pulse, parameters held.
        start();
        send_frame(BAD, 22, 0);
        push(2'b10, 4'b1000, P, last_cyc + 3);
        repeat (5) tick();

        // Non-Query command code; trailing bits ignored.
        start();
        send_frame(22'b1001 << 18, 4, 0);
        push(2'b11, 4'b1001, P, last_cyc + 1);
        check("nq_busy", busy, 0);
        send_frame(22'h2AAAAA, 6, 0);
        check("nq_ignored", {busy, crc5_sync}, 0);
        repeat (3) tick();

        // Reset mid-BODY abandons the frame and clears captured state.
        start();
        send_frame(pframe, 8, 0);
        check("pre_rst_data", {busy, crc5_sync, crc5_data}, 3'b111);
        rst_for_new_package = 1'b1;
        tick();
        rst_for_new_package = 1'b0;
        check("mid_rst_busy_pulses", {busy, query_ok, query_crc_err, not_query}, 0);
        check("mid_rst_sync_data", {crc5_sync, crc5_data}, 0);
        check("mid_rst_pkg_rst_n", {crc5_package_complete, crc5_rst_n}, 2'b10);
        check("mid_rst_cmd_param", {cmd_code, query_param}, 0);
        repeat (6) tick();

        // Abort after 10 bits, then a fresh good frame.
        start();
        send_frame(GOOD, 10, 2);
        frame_abort = 1'b1;
        tick();
        frame_abort = 1'b0;
        check("abort_idle", {busy, crc5_package_complete}, 2'b01);
        repeat (6) tick();
        start();
        send_frame(GOOD, 22, 0);
        push(2'b01, 4'b1000, 13'd0, last_cyc + 3);
        repeat (5) tick();

        // Bit coincident with frame_start is dropped.
        frame_start = 1'b1;
        data = 1'b1;
        data_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        data_valid = 1'b0;
        check("fs_dv_rst_n_low", crc5_rst_n, 0);
        check("fs_dv_no_sync", crc5_sync, 0);
        tick();
        check("fs_dv_rst_n_high", crc5_rst_n, 1);
        send_frame(GOOD, 22, 0);
        push(2'b01, 4'b1000, 13'd0, last_cyc + 3);

        repeat (10) tick();
        check("queue_drained", W'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
